// File: rtl/ddr_cmd_pipeline_bridge_if.sv
// Avalon-MM command/response bundle used on both sides of ddr_cmd_pipeline_bridge.
// The master modport drives commands; the slave modport drives waitrequest and read responses.
interface ddr_cmd_pipeline_bridge_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                endofpacket;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid, endofpacket
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid, endofpacket
  );
endinterface

// File: rtl/ddr_cmd_pipeline_bridge.sv
// Avalon-MM pipeline stage toward the DDR controller: 2-entry command skid buffer, read credit
// throttle and in-order read return. DDR_CMD_PIPELINE_BRIDGE_RSP_REG_EN registers the response path.
module ddr_cmd_pipeline_bridge #(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8,
  parameter int CNT_W       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  ddr_cmd_pipeline_bridge_if.slave  s,
  ddr_cmd_pipeline_bridge_if.master m,
  output logic [CNT_W-1:0]        pending_count
);

  localparam int               BE_W    = DATA_W / 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } occ_t;

  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wd;
  } cmd_t;

  occ_t             occ_p0, occ_n;
  cmd_t             main_p0, skid_p0, cmd_in;
  logic             wait_p0, wait_n;
  logic [CNT_W-1:0] cnt_p0, cnt_n;
  logic             main_vld;
  logic             accept, accept_rd, issue, main_free;
  logic             load_new, load_skid, promote;

  // Outstanding-read counter step, clamped to [0, MAX_PENDING].
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = (cnt >= MAX_CNT) ? MAX_CNT : cnt + 1'b1;
    end else if (dec && !inc) begin
      res = (cnt == '0) ? '0 : cnt - 1'b1;
    end
    return res;
  endfunction

  function automatic logic credit_stall(input logic [CNT_W-1:0] cnt);
    return cnt >= MAX_CNT;
  endfunction

  always_comb begin
    cmd_in      = '0;
    cmd_in.rd   = s.read;
    cmd_in.addr = s.address;
    cmd_in.be   = s.byteenable;
    cmd_in.wd   = s.writedata;
  end

  // Handshake decode: read wins when read and write are both asserted.
  always_comb begin
    main_vld  = (occ_p0 != OCC_EMPTY);
    accept    = (s.read | s.write) & ~wait_p0;
    accept_rd = accept & s.read;
    issue     = main_vld & ~m.waitrequest;
    main_free = ~main_vld | issue;
    load_new  = accept & main_free;
    load_skid = accept & ~main_free;
    promote   = (occ_p0 == OCC_TWO) & issue;
  end

  always_comb begin
    occ_n = occ_p0;
    case (occ_p0)
      OCC_EMPTY: if (accept) occ_n = OCC_ONE;
      OCC_ONE: begin
        if (accept && !issue)      occ_n = OCC_TWO;
        else if (!accept && issue) occ_n = OCC_EMPTY;
      end
      OCC_TWO:   if (issue) occ_n = OCC_ONE;
      default:   occ_n = OCC_EMPTY;
    endcase
    cnt_n  = sat_count(cnt_p0, accept_rd, m.readdatavalid);
    // pending_count already includes buffered reads, so only the counter gates credit.
    wait_n = (occ_n == OCC_TWO) | credit_stall(cnt_n);
  end

  // ---- stage p0: command buffer and control state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_p0  <= OCC_EMPTY;
      wait_p0 <= 1'b0;
      cnt_p0  <= '0;
      main_p0 <= '0;
    end else begin
      occ_p0  <= occ_n;
      wait_p0 <= wait_n;
      cnt_p0  <= cnt_n;
      if (promote) begin
        main_p0 <= skid_p0;
      end else if (load_new) begin
        main_p0 <= cmd_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_p0 <= cmd_in;
    end
  end

  assign m.address     = main_p0.addr;
  assign m.byteenable  = main_p0.be;
  assign m.writedata   = main_p0.wd;
  assign m.read        = main_vld & main_p0.rd;
  assign m.write       = main_vld & ~main_p0.rd;
  assign s.waitrequest = wait_p0;
  assign pending_count = cnt_p0;

`ifdef DDR_CMD_PIPELINE_BRIDGE_RSP_REG_EN
  logic [DATA_W-1:0] rsp_data_p0;
  logic              rsp_vld_p0;
  logic              rsp_eop_p0;

  // ---- stage p0: registered read response ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_p0  <= 1'b0;
      rsp_eop_p0  <= 1'b0;
      rsp_data_p0 <= '0;
    end else begin
      rsp_vld_p0  <= m.readdatavalid;
      rsp_eop_p0  <= m.endofpacket;
      rsp_data_p0 <= m.readdata;
    end
  end

  assign s.readdata      = rsp_data_p0;
  assign s.readdatavalid = rsp_vld_p0;
  assign s.endofpacket   = rsp_eop_p0;
`else
  assign s.readdata      = m.readdata;
  assign s.readdatavalid = m.readdatavalid;
  assign s.endofpacket   = m.endofpacket;
`endif

  // A full buffer always presents a stall, so nothing can be accepted into it.
  a_no_accept_when_full: assert property (@(posedge clk) disable iff (reset)
    !(accept && occ_p0 == OCC_TWO));
  a_count_bounded: assert property (@(posedge clk) disable iff (reset)
    cnt_p0 <= MAX_CNT);

endmodule

// File: tb/tb_ddr_cmd_pipeline_bridge.sv
// Directed bench for ddr_cmd_pipeline_bridge: reset, write streaming, stall/skid, read credit
// throttling, coincident count update and mid-operation reset.
module tb_ddr_cmd_pipeline_bridge;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] pending_count;
  int               checks = 0;
  int               errors = 0;

  ddr_cmd_pipeline_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();
  ddr_cmd_pipeline_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();

  ddr_cmd_pipeline_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .s(s_bus), .m(m_bus), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!reset && s_bus.read && s_bus.write) begin
      errors++;
      $display("FAIL illegal_rd_wr: got read=1 write=1 expected at most one");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_bus.address = '0; s_bus.byteenable = '0; s_bus.read = 1'b0; s_bus.write = 1'b0;
    s_bus.writedata = '0;
    m_bus.waitrequest = 1'b0; m_bus.readdata = '0; m_bus.readdatavalid = 1'b0;
    m_bus.endofpacket = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_bus.address = 27'($urandom()); s_bus.byteenable = 4'($urandom());
      s_bus.read = 1'($urandom()); s_bus.write = 1'($urandom());
      s_bus.writedata = $urandom();
      m_bus.waitrequest = 1'($urandom()); m_bus.readdata = $urandom();
      m_bus.readdatavalid = 1'($urandom()); m_bus.endofpacket = 1'($urandom());
      tick();
      checks++; if (s_bus.waitrequest !== 1'b0) begin errors++; $display("FAIL rst_wait[%0d]: got %b expected 0", i, s_bus.waitrequest); end
      checks++; if ({m_bus.read, m_bus.write} !== 2'b00) begin errors++; $display("FAIL rst_cmd[%0d]: got rd/wr %b expected 00", i, {m_bus.read, m_bus.write}); end
      checks++; if (pending_count !== 4'd0) begin errors++; $display("FAIL rst_cnt[%0d]: got %0d expected 0", i, pending_count); end
      checks++; if (m_bus.address !== 27'd0 || m_bus.writedata !== 32'd0 || m_bus.byteenable !== 4'd0) begin errors++; $display("FAIL rst_fields[%0d]: got addr %h data %h be %h expected zeros", i, m_bus.address, m_bus.writedata, m_bus.byteenable); end
`ifdef DDR_CMD_PIPELINE_BRIDGE_RSP_REG_EN
      checks++; if ({s_bus.readdatavalid, s_bus.endofpacket, s_bus.readdata} !== 34'd0) begin errors++; $display("FAIL rst_rsp[%0d]: got vld %b eop %b data %h expected zeros", i, s_bus.readdatavalid, s_bus.endofpacket, s_bus.readdata); end
`else
      checks++; if (s_bus.readdatavalid !== m_bus.readdatavalid || s_bus.readdata !== m_bus.readdata) begin errors++; $display("FAIL rst_rsp_pass[%0d]: got vld %b data %h expected vld %b data %h", i, s_bus.readdatavalid, s_bus.readdata, m_bus.readdatavalid, m_bus.readdata); end
`endif
    end
    idle_inputs();
    reset = 1'b0;
    tick();
    checks++; if (s_bus.waitrequest !== 1'b0) begin errors++; $display("FAIL rel_wait: got %b expected 0", s_bus.waitrequest); end
    checks++; if (pending_count !== 4'd0) begin errors++; $display("FAIL rel_cnt: got %0d expected 0", pending_count); end
  endtask

  task automatic test_back_to_back_writes();
    s_bus.byteenable = 4'hF;
    for (int i = 0; i < 4; i++) begin
      checks++; if (s_bus.waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_wait[%0d]: got %b expected 0", i, s_bus.waitrequest); end
      s_bus.write = 1'b1;
      s_bus.address = 27'(4 * i);
      s_bus.writedata = 32'hA0 + 32'(i);
      tick();
      checks++; if (m_bus.write !== 1'b1 || m_bus.read !== 1'b0) begin errors++; $display("FAIL b2b_wr[%0d]: got wr %b rd %b expected wr 1 rd 0", i, m_bus.write, m_bus.read); end
      checks++; if (m_bus.address !== 27'(4 * i) || m_bus.writedata !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL b2b_fields[%0d]: got addr %h data %h expected addr %h data %h", i, m_bus.address, m_bus.writedata, 4 * i, 32'hA0 + 32'(i)); end
    end
    s_bus.write = 1'b0;
    tick();
    checks++; if (m_bus.write !== 1'b0) begin errors++; $display("FAIL b2b_drain: got wr %b expected 0", m_bus.write); end
    checks++; if (s_bus.waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_wait_end: got %b expected 0", s_bus.waitrequest); end
  endtask

  task automatic test_stall_skid();
    logic [26:0] exp_addr [0:6];
    logic        exp_wait [0:6];
    exp_addr = '{27'h100, 27'h100, 27'h100, 27'h100, 27'h100, 27'h104, 27'h108};
    exp_wait = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    m_bus.waitrequest = 1'b1;
    s_bus.write = 1'b1; s_bus.address = 27'h100; s_bus.writedata = 32'hB0;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++; if (m_bus.write !== 1'b1 || m_bus.address !== exp_addr[c]) begin errors++; $display("FAIL stall_main[%0d]: got wr %b addr %h expected wr 1 addr %h", c, m_bus.write, m_bus.address, exp_addr[c]); end
      checks++; if (m_bus.writedata !== 32'hB0 + 32'((exp_addr[c] - 27'h100) >> 2)) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", c, m_bus.writedata, 32'hB0 + 32'((exp_addr[c] - 27'h100) >> 2)); end
      checks++; if (s_bus.waitrequest !== exp_wait[c]) begin errors++; $display("FAIL stall_wait[%0d]: got %b expected %b", c, s_bus.waitrequest, exp_wait[c]); end
      if (c == 0) begin s_bus.address = 27'h104; s_bus.writedata = 32'hB1; end
      if (c == 1) begin s_bus.address = 27'h108; s_bus.writedata = 32'hB2; end
      if (c == 4) m_bus.waitrequest = 1'b0;
      if (c == 6) s_bus.write = 1'b0;
    end
    tick();
    checks++; if (m_bus.write !== 1'b0) begin errors++; $display("FAIL stall_drain: got wr %b expected 0", m_bus.write); end
  endtask

  task automatic test_read_throttle();
    int accepted = 0;
    s_bus.read = 1'b1; s_bus.address = 27'h200; s_bus.byteenable = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (!s_bus.waitrequest) accepted++;
      tick();
    end
    checks++; if (accepted != 8) begin errors++; $display("FAIL thr_accepts: got %0d expected 8", accepted); end
    checks++; if (pending_count !== 4'd8) begin errors++; $display("FAIL thr_cnt: got %0d expected 8", pending_count); end
    checks++; if (s_bus.waitrequest !== 1'b1) begin errors++; $display("FAIL thr_wait: got %b expected 1", s_bus.waitrequest); end
    m_bus.readdatavalid = 1'b1; m_bus.readdata = 32'h12345678; m_bus.endofpacket = 1'b1;
    #1;
`ifndef DDR_CMD_PIPELINE_BRIDGE_RSP_REG_EN
    checks++; if ({s_bus.readdatavalid, s_bus.endofpacket, s_bus.readdata} !== {2'b11, 32'h12345678}) begin errors++; $display("FAIL thr_rsp_pass: got vld %b eop %b data %h expected 1 1 12345678", s_bus.readdatavalid, s_bus.endofpacket, s_bus.readdata); end
`endif
    tick();
`ifdef DDR_CMD_PIPELINE_BRIDGE_RSP_REG_EN
    checks++; if ({s_bus.readdatavalid, s_bus.endofpacket, s_bus.readdata} !== {2'b11, 32'h12345678}) begin errors++; $display("FAIL thr_rsp_reg: got vld %b eop %b data %h expected 1 1 12345678", s_bus.readdatavalid, s_bus.endofpacket, s_bus.readdata); end
`endif
    m_bus.readdatavalid = 1'b0; m_bus.endofpacket = 1'b0;
    checks++; if (pending_count !== 4'd7) begin errors++; $display("FAIL thr_cnt_dec: got %0d expected 7", pending_count); end
    checks++; if (s_bus.waitrequest !== 1'b0) begin errors++; $display("FAIL thr_wait_drop: got %b expected 0", s_bus.waitrequest); end
    tick();
    s_bus.read = 1'b0;
    checks++; if (pending_count !== 4'd8) begin errors++; $display("FAIL thr_ninth: got %0d expected 8", pending_count); end
    checks++; if (s_bus.waitrequest !== 1'b1) begin errors++; $display("FAIL thr_wait_again: got %b expected 1", s_bus.waitrequest); end
    checks++; if (s_bus.readdatavalid !== 1'b0) begin errors++; $display("FAIL thr_rsp_once: got %b expected 0", s_bus.readdatavalid); end
    m_bus.readdatavalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      m_bus.readdata = 32'(c);
      tick();
    end
    m_bus.readdatavalid = 1'b0;
    checks++; if (pending_count !== 4'd3) begin errors++; $display("FAIL thr_drain_cnt: got %0d expected 3", pending_count); end
    checks++; if (s_bus.waitrequest !== 1'b0) begin errors++; $display("FAIL thr_drain_wait: got %b expected 0", s_bus.waitrequest); end
  endtask

  task automatic test_coincident();
    s_bus.read = 1'b1; s_bus.address = 27'h280; m_bus.readdatavalid = 1'b1;
    tick();
    s_bus.read = 1'b0; m_bus.readdatavalid = 1'b0;
    checks++; if (pending_count !== 4'd3) begin errors++; $display("FAIL coinc_cnt: got %0d expected 3", pending_count); end
    checks++; if (m_bus.read !== 1'b1 || m_bus.address !== 27'h280) begin errors++; $display("FAIL coinc_issue: got rd %b addr %h expected rd 1 addr 280", m_bus.read, m_bus.address); end
    tick();
    checks++; if (pending_count !== 4'd3) begin errors++; $display("FAIL coinc_hold: got %0d expected 3", pending_count); end
  endtask

  task automatic test_reset_mid_op();
    s_bus.read = 1'b1; s_bus.address = 27'h2C0;
    tick();
    s_bus.read = 1'b0;
    tick();
    m_bus.waitrequest = 1'b1;
    s_bus.write = 1'b1; s_bus.address = 27'h300; s_bus.writedata = 32'hC0;
    tick();
    s_bus.address = 27'h304; s_bus.writedata = 32'hC1;
    tick();
    s_bus.write = 1'b0;
    checks++; if (pending_count !== 4'd4) begin errors++; $display("FAIL mid_cnt: got %0d expected 4", pending_count); end
    checks++; if (m_bus.write !== 1'b1 || m_bus.address !== 27'h300 || s_bus.waitrequest !== 1'b1) begin errors++; $display("FAIL mid_buf: got wr %b addr %h wait %b expected 1 300 1", m_bus.write, m_bus.address, s_bus.waitrequest); end
    reset = 1'b1;
    tick();
    checks++; if ({m_bus.read, m_bus.write} !== 2'b00) begin errors++; $display("FAIL mid_rst_cmd: got rd/wr %b expected 00", {m_bus.read, m_bus.write}); end
    checks++; if (pending_count !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", pending_count); end
    checks++; if (s_bus.readdatavalid !== 1'b0 || s_bus.waitrequest !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp: got vld %b wait %b expected 0 0", s_bus.readdatavalid, s_bus.waitrequest); end
    reset = 1'b0; m_bus.waitrequest = 1'b0; m_bus.readdatavalid = 1'b1;
    tick();
    m_bus.readdatavalid = 1'b0;
    checks++; if (pending_count !== 4'd0) begin errors++; $display("FAIL stale_cnt: got %0d expected 0", pending_count); end
    checks++; if (m_bus.write !== 1'b0) begin errors++; $display("FAIL stale_cmd: got wr %b expected 0", m_bus.write); end
    tick();
    checks++; if (pending_count !== 4'd0 || m_bus.write !== 1'b0) begin errors++; $display("FAIL stale_hold: got cnt %0d wr %b expected 0 0", pending_count, m_bus.write); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_back_to_back_writes();
    test_stall_skid();
    test_read_throttle();
    test_coincident();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
